// File: rtl/memory_port_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port between instruction
// fetch and data load/store, with fixed read latency and per-requester done pulses.
module memory_port_arbiter #(
  parameter int LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetchRequest,
  input  logic [31:0] fetchAddress,
  output logic        fetchDone,
  output logic [31:0] fetchData,
  input  logic        dataRequest,
  input  logic        dataWrite,
  input  logic [31:0] dataAddress,
  input  logic [31:0] dataWriteData,
  input  logic [3:0]  dataByteEnable,
  output logic        dataDone,
  output logic [31:0] dataReadData,
  output logic [29:0] memAddress,
  output logic        memWriteEnable,
  output logic [3:0]  memByteEnable,
  output logic [31:0] memWriteData,
  input  logic [31:0] memReadData,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE} stateT;

  stateT       stateReg;
  stateT       stateNext;
  logic        ownerData;      // 1 = data port owns the current access
  logic        lastGrantData;  // 1 = most recent grant went to data
  logic        writeOp;
  logic [3:0]  counter;
  logic        grantValid;
  logic        grantData;

  // Byte-offset bits are meaningless on a word-wide port.
  logic unusedAddrBits;
  assign unusedAddrBits = ^{fetchAddress[1:0], dataAddress[1:0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    grantValid = fetchRequest | dataRequest;
    // On a tie, the requester that did not win last time gets the port.
    grantData  = dataRequest & (~fetchRequest | ~lastGrantData);
    stateNext  = stateReg;
    fetchDone  = 1'b0;
    dataDone   = 1'b0;
    busy       = (stateReg != IDLE);
    case (stateReg)
      IDLE: begin
        if (grantValid) stateNext = ACCESS;
      end
      ACCESS: begin
        if (writeOp || counter == 4'd0) stateNext = COMPLETE;
      end
      COMPLETE: begin
        fetchDone = ~ownerData;
        dataDone  = ownerData;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ownerData      <= 1'b0;
      lastGrantData  <= 1'b0;
      writeOp        <= 1'b0;
      counter        <= 4'd0;
      memAddress     <= 30'd0;
      memWriteEnable <= 1'b0;
      memByteEnable  <= 4'd0;
      memWriteData   <= 32'd0;
      fetchData      <= 32'd0;
      dataReadData   <= 32'd0;
    end else begin
      case (stateReg)
        IDLE: begin
          memWriteEnable <= 1'b0;
          if (grantValid) begin
            ownerData     <= grantData;
            lastGrantData <= grantData;
            counter       <= 4'(LATENCY);
            if (grantData) begin
              memAddress     <= dataAddress[31:2];
              writeOp        <= dataWrite;
              memWriteEnable <= dataWrite;
              memByteEnable  <= dataByteEnable;
              memWriteData   <= dataWriteData;
            end else begin
              memAddress     <= fetchAddress[31:2];
              writeOp        <= 1'b0;
              memByteEnable  <= 4'd0;
              memWriteData   <= 32'd0;
            end
          end
        end
        ACCESS: begin
          // The store strobe lives only in the first access cycle.
          memWriteEnable <= 1'b0;
          if (!writeOp) begin
            if (counter == 4'd0) begin
              if (ownerData) dataReadData <= memReadData;
              else           fetchData    <= memReadData;
            end else begin
              counter <= counter - 4'd1;
            end
          end
        end
        default: begin
          memWriteEnable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: one instance per latency (1,2,3,15) sharing
// stimulus; checks target the instance selected by sel.
module tb_memory_port_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        fetchRequest, dataRequest, dataWrite;
  logic [31:0] fetchAddress, dataAddress, dataWriteData;
  logic [3:0]  dataByteEnable;
  logic        ovEn;
  logic [31:0] ovVal;

  logic        fetchDoneA[4], dataDoneA[4], memWeA[4], busyA[4];
  logic [31:0] fetchDataA[4], dataReadDataA[4], memWdA[4], memRdA[4];
  logic [29:0] memAddrA[4];
  logic [3:0]  memBeA[4];

  int checks = 0;
  int errors = 0;
  int sel = 0;
  int cyc = 0;

  function automatic logic [31:0] memWord(input logic [29:0] a);
    return ({a, 2'b00} * 32'h9E3779B1) ^ 32'hC001D00D;
  endfunction

  function automatic int latOf(input int s);
    case (s)
      0: return 1;
      1: return 2;
      2: return 3;
      default: return 15;
    endcase
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    localparam int L = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 3 : 15;
    assign memRdA[gi] = ovEn ? ovVal : memWord(memAddrA[gi]);
    memory_port_arbiter #(.LATENCY(L)) dut (
      .clock(clock), .reset(reset),
      .fetchRequest(fetchRequest), .fetchAddress(fetchAddress),
      .fetchDone(fetchDoneA[gi]), .fetchData(fetchDataA[gi]),
      .dataRequest(dataRequest), .dataWrite(dataWrite), .dataAddress(dataAddress),
      .dataWriteData(dataWriteData), .dataByteEnable(dataByteEnable),
      .dataDone(dataDoneA[gi]), .dataReadData(dataReadDataA[gi]),
      .memAddress(memAddrA[gi]), .memWriteEnable(memWeA[gi]),
      .memByteEnable(memBeA[gi]), .memWriteData(memWdA[gi]),
      .memReadData(memRdA[gi]), .busy(busyA[gi])
    );
  end

  // Requests must be held until their done pulse.
  logic protoOn = 1'b0;
  logic fPendA = 1'b0;
  logic dPendA = 1'b0;
  always @(negedge clock) begin
    if (protoOn) begin
      assert (!(fPendA && !fetchRequest && !fetchDoneA[sel]))
        else $error("protocol violation: fetchRequest dropped before fetchDone");
      assert (!(dPendA && !dataRequest && !dataDoneA[sel]))
        else $error("protocol violation: dataRequest dropped before dataDone");
      if (fetchDoneA[sel]) fPendA <= 1'b0; else if (fetchRequest) fPendA <= 1'b1;
      if (dataDoneA[sel])  dPendA <= 1'b0; else if (dataRequest)  dPendA <= 1'b1;
    end else begin
      fPendA <= 1'b0;
      dPendA <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut=%0d cycle=%0d got=%h expected=%h", name, sel, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic doReset();
    reset = 1'b1; fetchRequest = 1'b0; dataRequest = 1'b0; dataWrite = 1'b0;
    fetchAddress = 32'd0; dataAddress = 32'd0; dataWriteData = 32'd0; dataByteEnable = 4'd0;
    step();
    step();
    reset = 1'b0;
    cyc = 0;
  endtask

  typedef struct {
    logic fReq; logic [31:0] fAddr; logic dReq; logic dWr; logic [31:0] dAddr; logic [31:0] dWd;
    logic [3:0] dBe; logic [31:0] rd;
    logic eF; logic eD; logic eBusy; logic eWe; logic [29:0] eAddr; logic [31:0] eFData;
    logic [31:0] eDRd; logic chkW; logic [3:0] eBe; logic [31:0] eWd;
  } vecT;

  vecT vecs[10];

  // Random-test model state
  int grantAt, freeAt, doneAt, strobeAt;
  logic gData, gWrite, lastData, fPend, dPend, eF, eD, eBusy, eWe;
  logic [29:0] gAddr, expAddr;
  logic [3:0]  gBe;
  logic [31:0] gWd, expFData, expDRd;
  int doneCyc[$];
  logic doneOwner[$];

  initial begin
    ovEn = 1'b0; ovVal = 32'd0;

    // Fetch read at LATENCY=2, then a store, on the LATENCY=2 instance.
    vecs[0] = '{1, 32'h100, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 30'h000, 32'h0, 32'h0, 0, 4'h0, 32'h0};
    vecs[1] = '{1, 32'h100, 0, 0, 0, 0, 0, 32'h0,        0, 0, 1, 0, 30'h040, 32'h0, 32'h0, 0, 4'h0, 32'h0};
    vecs[2] = '{1, 32'h100, 0, 0, 0, 0, 0, 32'h0,        0, 0, 1, 0, 30'h040, 32'h0, 32'h0, 0, 4'h0, 32'h0};
    vecs[3] = '{1, 32'h100, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 1, 0, 30'h040, 32'h0, 32'h0, 0, 4'h0, 32'h0};
    vecs[4] = '{0, 32'h100, 0, 0, 0, 0, 0, 32'h0,        1, 0, 1, 0, 30'h040, 32'hDEADBEEF, 32'h0, 0, 4'h0, 32'h0};
    vecs[5] = '{0, 32'h0,   0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 30'h040, 32'hDEADBEEF, 32'h0, 0, 4'h0, 32'h0};
    vecs[6] = '{0, 32'h0, 1, 1, 32'h208, 32'h12345678, 4'b0011, 32'h0, 0, 0, 0, 0, 30'h040, 32'hDEADBEEF, 32'h0, 0, 4'h0, 32'h0};
    vecs[7] = '{0, 32'h0, 1, 1, 32'h208, 32'h12345678, 4'b0011, 32'h0, 0, 0, 1, 1, 30'h082, 32'hDEADBEEF, 32'h0, 1, 4'b0011, 32'h12345678};
    vecs[8] = '{0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 0, 1, 1, 0, 30'h082, 32'hDEADBEEF, 32'h0, 0, 4'h0, 32'h0};
    vecs[9] = '{0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 0, 30'h082, 32'hDEADBEEF, 32'h0, 0, 4'h0, 32'h0};

    sel = 1;
    doReset();
    ovEn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      fetchRequest = vecs[i].fReq; fetchAddress = vecs[i].fAddr;
      dataRequest = vecs[i].dReq; dataWrite = vecs[i].dWr; dataAddress = vecs[i].dAddr;
      dataWriteData = vecs[i].dWd; dataByteEnable = vecs[i].dBe; ovVal = vecs[i].rd;
      #1;
      chk("vec_fetchDone", 32'(fetchDoneA[sel]), 32'(vecs[i].eF));
      chk("vec_dataDone", 32'(dataDoneA[sel]), 32'(vecs[i].eD));
      chk("vec_busy", 32'(busyA[sel]), 32'(vecs[i].eBusy));
      chk("vec_memWriteEnable", 32'(memWeA[sel]), 32'(vecs[i].eWe));
      chk("vec_memAddress", 32'(memAddrA[sel]), 32'(vecs[i].eAddr));
      chk("vec_fetchData", fetchDataA[sel], vecs[i].eFData);
      chk("vec_dataReadData", dataReadDataA[sel], vecs[i].eDRd);
      if (vecs[i].chkW) begin
        chk("vec_memByteEnable", 32'(memBeA[sel]), 32'(vecs[i].eBe));
        chk("vec_memWriteData", memWdA[sel], vecs[i].eWd);
      end
      step();
    end
    ovEn = 1'b0;

    // Tie alternation at LATENCY=1: D,F,D,F completing at 3,7,11,15.
    sel = 0;
    doReset();
    doneCyc.delete(); doneOwner.delete();
    for (int c = 0; c < 40 && doneCyc.size() < 4; c++) begin
      fetchRequest = 1'b1; fetchAddress = 32'h1000;
      dataRequest = 1'b1; dataWrite = 1'b0; dataAddress = 32'h2000;
      #1;
      chk("tie_both_done", 32'(fetchDoneA[sel] & dataDoneA[sel]), 32'd0);
      if (dataDoneA[sel]) begin
        doneCyc.push_back(cyc); doneOwner.push_back(1'b1);
        chk("tie_dataReadData", dataReadDataA[sel], memWord(30'h800));
      end else if (fetchDoneA[sel]) begin
        doneCyc.push_back(cyc); doneOwner.push_back(1'b0);
        chk("tie_fetchData", fetchDataA[sel], memWord(30'h400));
      end
      step();
    end
    chk("tie_done_count", 32'(doneCyc.size()), 32'd4);
    for (int k = 0; k < doneCyc.size() && k < 4; k++) begin
      chk("tie_owner", 32'(doneOwner[k]), 32'(k % 2 == 0));
      chk("tie_done_cycle", 32'(doneCyc[k]), 32'(3 + 4 * k));
    end

    // Back-to-back fetches at LATENCY=1 with the request held.
    doReset();
    for (int c = 0; c < 14; c++) begin
      fetchRequest = 1'b1; fetchAddress = 32'h40;
      #1;
      chk("b2b_fetchDone", 32'(fetchDoneA[sel]), 32'(c == 3 || c == 7 || c == 11));
      step();
    end

    // Reset during a LATENCY=3 read.
    sel = 2;
    doReset();
    for (int c = 0; c < 10; c++) begin
      fetchRequest = (c < 3); fetchAddress = 32'h500;
      reset = (c == 2);
      #1;
      chk("rst_fetchDone", 32'(fetchDoneA[sel]), 32'd0);
      if (c == 2) chk("rst_busy_before", 32'(busyA[sel]), 32'd1);
      if (c == 3) begin
        chk("rst_busy", 32'(busyA[sel]), 32'd0);
        chk("rst_memAddress", 32'(memAddrA[sel]), 32'd0);
        chk("rst_memWriteEnable", 32'(memWeA[sel]), 32'd0);
        chk("rst_fetchData", fetchDataA[sel], 32'd0);
      end
      step();
    end
    reset = 1'b0;

    // LATENCY=15 read with a data request arriving mid-access.
    sel = 3;
    doReset();
    for (int c = 0; c < 21; c++) begin
      fetchRequest = (c < 18); fetchAddress = 32'h300;
      dataRequest = (c >= 5); dataWrite = 1'b0; dataAddress = 32'h400;
      #1;
      chk("l15_fetchDone", 32'(fetchDoneA[sel]), 32'(c == 17));
      chk("l15_memAddress", 32'(memAddrA[sel]), (c == 0) ? 32'h0 : (c <= 18) ? 32'hC0 : 32'h100);
      chk("l15_busy", 32'(busyA[sel]), 32'(c != 0 && c != 18));
      step();
    end

    // Randomized traffic against a cycle-arithmetic transaction model.
    for (int s = 0; s < 4; s++) begin
      sel = s;
      doReset();
      grantAt = -100; freeAt = 0; doneAt = -1; strobeAt = -1;
      gData = 1'b0; gWrite = 1'b0; lastData = 1'b0; fPend = 1'b0; dPend = 1'b0;
      gAddr = '0; expAddr = '0; gBe = '0; gWd = '0; expFData = '0; expDRd = '0;
      protoOn = 1'b1;
      for (int c = 0; c < 250; c++) begin
        if (!fPend) begin
          fetchRequest = ($urandom_range(0, 2) == 0);
          fetchAddress = $urandom;
          fPend = fetchRequest;
        end
        if (!dPend) begin
          dataRequest = ($urandom_range(0, 2) == 0);
          dataWrite = 1'($urandom_range(0, 1));
          dataAddress = $urandom; dataWriteData = $urandom;
          dataByteEnable = 4'($urandom_range(0, 15));
          dPend = dataRequest;
        end
        if (c == grantAt + 1) expAddr = gAddr;
        eBusy = (c > grantAt) && (c < freeAt);
        eF = (c == doneAt) && !gData;
        eD = (c == doneAt) && gData;
        eWe = (c == strobeAt);
        if (c == doneAt && !gWrite) begin
          if (gData) expDRd = memWord(gAddr);
          else       expFData = memWord(gAddr);
        end
        #1;
        chk("rnd_busy", 32'(busyA[sel]), 32'(eBusy));
        chk("rnd_fetchDone", 32'(fetchDoneA[sel]), 32'(eF));
        chk("rnd_dataDone", 32'(dataDoneA[sel]), 32'(eD));
        chk("rnd_memWriteEnable", 32'(memWeA[sel]), 32'(eWe));
        chk("rnd_memAddress", 32'(memAddrA[sel]), 32'(expAddr));
        chk("rnd_fetchData", fetchDataA[sel], expFData);
        chk("rnd_dataReadData", dataReadDataA[sel], expDRd);
        if (eWe) begin
          chk("rnd_memByteEnable", 32'(memBeA[sel]), 32'(gBe));
          chk("rnd_memWriteData", memWdA[sel], gWd);
        end
        if (c >= freeAt && (fetchRequest || dataRequest)) begin
          gData = dataRequest && (!fetchRequest || !lastData);
          lastData = gData;
          grantAt = c;
          gWrite = gData && dataWrite;
          gAddr = gData ? dataAddress[31:2] : fetchAddress[31:2];
          gBe = dataByteEnable; gWd = dataWriteData;
          if (gWrite) begin
            strobeAt = c + 1; doneAt = c + 2; freeAt = c + 3;
          end else begin
            strobeAt = -1; doneAt = c + 2 + latOf(s); freeAt = c + 3 + latOf(s);
          end
        end
        if (eF) fPend = 1'b0;
        if (eD) dPend = 1'b0;
        step();
      end
      protoOn = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
